// File: rtl/vector_lsu.sv
// Vector load/store unit: moves LANES 32-bit words between a vector register and data memory, one lane per cycle.
// Optional feature: define VLSU_STRIDE_EN to add a run-time stride port; otherwise lanes are STRIDE_DEF bytes apart.
module vector_lsu #(
    parameter int          LANES      = 4,
    parameter logic [31:0] STRIDE_DEF = 32'd4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  is_store,
    input  logic [31:0]           base_addr,
`ifdef VLSU_STRIDE_EN
    input  logic [31:0]           stride,
`endif
    input  logic [LANES*32-1:0]   store_vec,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [LANES*32-1:0]   load_vec,
    output logic [31:0]           mem_adr,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         lane_q, lane_d;
    logic                  store_q, store_d;
    logic [31:0]           addr_q, addr_d;
    logic [LANES*32-1:0]   data_q, data_d;
    logic [LANES*32-1:0]   load_q, load_d;
    logic                  err_q, err_d;
    logic [31:0]           req_stride;
    logic [31:0]           cur_stride;

`ifdef VLSU_STRIDE_EN
    logic [31:0]           stride_q, stride_d;
    assign req_stride = stride;
    assign cur_stride = stride_q;
`else
    assign req_stride = STRIDE_DEF;
    assign cur_stride = STRIDE_DEF;
`endif

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        store_d = store_q;
        addr_d  = addr_q;
        data_d  = data_q;
        load_d  = load_q;
        err_d   = 1'b0;
`ifdef VLSU_STRIDE_EN
        stride_d = stride_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    // A misaligned request completes immediately with error and never touches memory.
                    if ((base_addr[1:0] != 2'b00) || (req_stride[1:0] != 2'b00)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ACCESS;
                        lane_d  = '0;
                        store_d = is_store;
                        addr_d  = base_addr;
                        data_d  = store_vec;
`ifdef VLSU_STRIDE_EN
                        stride_d = stride;
`endif
                    end
                end
            end
            ACCESS: begin
                addr_d = addr_q + cur_stride;
                data_d = data_q >> 32;
                if (!store_q) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (lane_q == LW'(i)) load_d[i*32 +: 32] = mem_rdata;
                    end
                end
                if (lane_q == LW'(LANES - 1)) begin
                    state_d = DONE;
                    lane_d  = '0;
                end else begin
                    lane_d = lane_q + LW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lane_q  <= '0;
            store_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            load_q  <= '0;
            err_q   <= 1'b0;
`ifdef VLSU_STRIDE_EN
            stride_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            store_q <= store_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            load_q  <= load_d;
            err_q   <= err_d;
`ifdef VLSU_STRIDE_EN
            stride_q <= stride_d;
`endif
        end
    end

    logic in_access;
    assign in_access = (state_q == ACCESS);

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign error     = done & err_q;
    assign load_vec  = load_q;
    // Reset suppresses the write of the cycle it arrives in, so an aborted store stops immediately.
    assign mem_we    = in_access & store_q & ~reset;
    assign mem_adr   = in_access ? addr_q : 32'd0;
    assign mem_wdata = (in_access && store_q) ? data_q[31:0] : 32'd0;

endmodule

// File: tb/tb_vector_lsu.sv
// Self-checking bench for vector_lsu: memory model, address-level reference model, directed and random requests.
module tb_vector_lsu;

    localparam int LANES = 4;
    localparam int VW    = LANES * 32;

    logic          clk = 1'b0;
    logic          reset, start, is_store;
    logic [31:0]   base_addr;
`ifdef VLSU_STRIDE_EN
    logic [31:0]   stride;
`endif
    logic [VW-1:0] store_vec;
    logic          busy, done, error, mem_we;
    logic [VW-1:0] load_vec;
    logic [31:0]   mem_adr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vector_lsu dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_store  (is_store),
        .base_addr (base_addr),
`ifdef VLSU_STRIDE_EN
        .stride    (stride),
`endif
        .store_vec (store_vec),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .load_vec  (load_vec),
        .mem_adr   (mem_adr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Data memory (bench side) and the reference model's own view of memory.
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    logic [63:0]   exp_q[$];
    logic [63:0]   act_q[$];
    logic [31:0]   exp_adr_q[$];
    logic [31:0]   adr_log[$];
    logic [VW-1:0] exp_load = '0;
    bit            exp_err;
    int            exp_lat;
    int            we_cnt;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory and bus monitor, sampled on the falling edge.
    always @(negedge clk) begin
        mem_rdata = mem.exists(mem_adr) ? mem[mem_adr] : dflt(mem_adr);
        if (mem_we === 1'b1) begin
            mem[mem_adr] = mem_wdata;
            act_q.push_back({mem_adr, mem_wdata});
            we_cnt++;
        end
        if (busy === 1'b1 && done === 1'b0 && reset === 1'b0) adr_log.push_back(mem_adr);
        if (busy === 1'b0 || done === 1'b1) begin
            total++;
            if (mem_we !== 1'b0 || mem_adr !== 32'd0 || mem_wdata !== 32'd0) begin
                bad++;
                $display("FAIL idle_bus t=%0t we=%b adr=%h wdata=%h required all zero", $time, mem_we, mem_adr, mem_wdata);
            end
        end
    end

    // Drives one request and records what the reference model predicts for it.
    task automatic issue(input bit st, input logic [31:0] b, input logic [31:0] s, input logic [VW-1:0] v);
        logic [31:0] eff, a;
        exp_q.delete(); act_q.delete(); exp_adr_q.delete(); adr_log.delete(); we_cnt = 0;
`ifdef VLSU_STRIDE_EN
        eff = s;
`else
        eff = 32'd4;
        if (s == 32'hDEAD_BEEF) eff = 32'd4;
`endif
        exp_err = (b % 4 != 0) || (eff % 4 != 0);
        exp_lat = exp_err ? 1 : LANES + 1;
        if (!exp_err) begin
            for (int i = 0; i < LANES; i++) begin
                a = b + i * eff;
                exp_adr_q.push_back(a);
                if (st) begin
                    exp_q.push_back({a, v[i*32 +: 32]});
                    ref_mem[a] = v[i*32 +: 32];
                end else begin
                    exp_load[i*32 +: 32] = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
                end
            end
        end
        @(posedge clk); #1;
        start = 1'b1; is_store = st; base_addr = b; store_vec = v;
`ifdef VLSU_STRIDE_EN
        stride = s;
`endif
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic err);
        lat = -1; err = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = c; err = error;
                break;
            end
        end
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; is_store = 1'b0; base_addr = '0; store_vec = '0;
`ifdef VLSU_STRIDE_EN
        stride = 32'd4;
`endif
        repeat (2) @(negedge clk);
        total += 5;
        if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        if (error !== 1'b0)    begin bad++; $display("FAIL reset_error got=%b want=0", error); end
        if (load_vec !== '0)   begin bad++; $display("FAIL reset_load_vec got=%h want=0", load_vec); end
        if (mem_we !== 1'b0)   begin bad++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        int lat; logic err;
        issue(1'b1, 32'h100, 32'd4, {32'hD, 32'hC, 32'hB, 32'hA});
        wait_done(lat, err);
        total += 3;
        if (lat !== 5)   begin bad++; $display("FAIL store_latency got=%0d want=5", lat); end
        if (err !== 1'b0) begin bad++; $display("FAIL store_error got=%b want=0", err); end
        if (act_q.size() !== 4) begin bad++; $display("FAIL store_count got=%0d want=4", act_q.size()); end
        else begin
            total += 6;
            if (act_q[0] !== {32'h100, 32'hA}) begin bad++; $display("FAIL store_lane0 got=%h want=%h", act_q[0], {32'h100, 32'hA}); end
            if (act_q[3] !== {32'h10C, 32'hD}) begin bad++; $display("FAIL store_lane3 got=%h want=%h", act_q[3], {32'h10C, 32'hD}); end
            for (int i = 0; i < 4; i++)
                if (act_q[i] !== exp_q[i]) begin bad++; $display("FAIL store_write%0d got=%h want=%h", i, act_q[i], exp_q[i]); end
        end
        issue(1'b0, 32'h100, 32'd4, '0);
        wait_done(lat, err);
        total += 5;
        if (lat !== 5)    begin bad++; $display("FAIL load_latency got=%0d want=5", lat); end
        if (err !== 1'b0) begin bad++; $display("FAIL load_error got=%b want=0", err); end
        if (we_cnt !== 0) begin bad++; $display("FAIL load_we got=%0d want=0", we_cnt); end
        if (load_vec !== {32'hD, 32'hC, 32'hB, 32'hA}) begin bad++; $display("FAIL load_vec_literal got=%h", load_vec); end
        if (load_vec !== exp_load) begin bad++; $display("FAIL load_vec_model got=%h want=%h", load_vec, exp_load); end
    endtask

    task automatic test_misaligned();
        int lat; logic err;
        for (int k = 0; k < 2; k++) begin
            issue(k[0], (k == 0) ? 32'h102 : 32'h201, 32'd4, rand_vec());
            wait_done(lat, err);
            total += 5;
            if (lat !== 1)            begin bad++; $display("FAIL misalign%0d_latency got=%0d want=1", k, lat); end
            if (err !== 1'b1)         begin bad++; $display("FAIL misalign%0d_error got=%b want=1", k, err); end
            if (we_cnt !== 0)         begin bad++; $display("FAIL misalign%0d_we got=%0d want=0", k, we_cnt); end
            if (adr_log.size() !== 0) begin bad++; $display("FAIL misalign%0d_access got=%0d want=0", k, adr_log.size()); end
            if (load_vec !== exp_load) begin bad++; $display("FAIL misalign%0d_load_vec got=%h want=%h", k, load_vec, exp_load); end
        end
`ifdef VLSU_STRIDE_EN
        issue(1'b0, 32'h100, 32'd6, '0);
        wait_done(lat, err);
        total += 2;
        if (lat !== 1 || err !== 1'b1) begin bad++; $display("FAIL stride_misalign got lat=%0d err=%b want lat=1 err=1", lat, err); end
        if (we_cnt !== 0) begin bad++; $display("FAIL stride_misalign_we got=%0d want=0", we_cnt); end
`endif
    endtask

    task automatic test_wrap();
        int lat; logic err;
        issue(1'b1, 32'hFFFF_FFF8, 32'd8, rand_vec());
        wait_done(lat, err);
        total += 2;
        if (lat !== 5 || err !== 1'b0) begin bad++; $display("FAIL wrap_done got lat=%0d err=%b want lat=5 err=0", lat, err); end
        if (adr_log.size() !== 4) begin bad++; $display("FAIL wrap_count got=%0d want=4", adr_log.size()); end
        else begin
            total += 5;
`ifdef VLSU_STRIDE_EN
            if (adr_log[1] !== 32'h0) begin bad++; $display("FAIL wrap_lane1 got=%h want=00000000", adr_log[1]); end
`else
            if (adr_log[2] !== 32'h0) begin bad++; $display("FAIL wrap_lane2 got=%h want=00000000", adr_log[2]); end
`endif
            for (int i = 0; i < 4; i++)
                if (adr_log[i] !== exp_adr_q[i]) begin bad++; $display("FAIL wrap_adr%0d got=%h want=%h", i, adr_log[i], exp_adr_q[i]); end
        end
    endtask

    task automatic test_random();
        int lat; logic err; bit st; logic [31:0] b, s;
        for (int n = 0; n < 24; n++) begin
            st = 1'($urandom_range(0, 1));
            b  = ($urandom_range(0, 7) == 0) ? 32'h2000 + $urandom_range(0, 255) : 32'h2000 + 4 * $urandom_range(0, 63);
`ifdef VLSU_STRIDE_EN
            case ($urandom_range(0, 5))
                0: s = 32'd4;
                1: s = 32'd8;
                2: s = 32'd0;
                3: s = 32'hFFFF_FFFC;
                4: s = 32'd16;
                default: s = $urandom_range(1, 3);
            endcase
`else
            s = $urandom;
`endif
            issue(st, b, s, rand_vec());
            wait_done(lat, err);
            total += 5;
            if (lat !== exp_lat)  begin bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", n, lat, exp_lat); end
            if (err !== exp_err)  begin bad++; $display("FAIL rand%0d_error got=%b want=%b", n, err, exp_err); end
            if (adr_log != exp_adr_q) begin bad++; $display("FAIL rand%0d_addresses got_n=%0d want_n=%0d", n, adr_log.size(), exp_adr_q.size()); end
            if (act_q != exp_q)   begin bad++; $display("FAIL rand%0d_writes got_n=%0d want_n=%0d", n, act_q.size(), exp_q.size()); end
            if (load_vec !== exp_load) begin bad++; $display("FAIL rand%0d_load_vec got=%h want=%h", n, load_vec, exp_load); end
        end
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] v; int dones;
        v = rand_vec();
        issue(1'b1, 32'h300, 32'd4, v);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 1; i < LANES; i++) ref_mem.delete(32'h300 + 4 * i);
        exp_load = '0;
        total += 4;
        if (busy !== 1'b0)     begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        if (load_vec !== exp_load) begin bad++; $display("FAIL abort_load_vec got=%h want=0", load_vec); end
        if (we_cnt !== 1)      begin bad++; $display("FAIL abort_we got=%0d want=1", we_cnt); end
        if (act_q.size() < 1 || act_q[0] !== {32'h300, v[31:0]}) begin bad++; $display("FAIL abort_lane0 got_n=%0d want=%h", act_q.size(), {32'h300, v[31:0]}); end
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones !== 0 || we_cnt !== 1) begin bad++; $display("FAIL abort_done got=%0d dones %0d writes want 0 dones 1 write", dones, we_cnt); end
    endtask

    task automatic test_start_busy();
        int lat, dones, first; logic err; logic [VW-1:0] v;
        v = rand_vec();
        issue(1'b1, 32'h400, 32'd4, v);
        @(posedge clk); #1;
        start = 1'b1; is_store = 1'b0; base_addr = 32'h500;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0; first = -1;
        for (int c = 3; c <= 12; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin dones++; if (first < 0) first = c; end
        end
        total += 3;
        if (dones !== 1) begin bad++; $display("FAIL busy_start_dones got=%0d want=1", dones); end
        if (first !== 5) begin bad++; $display("FAIL busy_start_done_cycle got=%0d want=5", first); end
        if (act_q != exp_q) begin bad++; $display("FAIL busy_start_writes got_n=%0d want_n=%0d", act_q.size(), exp_q.size()); end
        issue(1'b0, 32'h400, 32'd4, '0);
        wait_done(lat, err);
        total += 2;
        if (lat !== 5 || err !== 1'b0) begin bad++; $display("FAIL after_busy_accept got lat=%0d err=%b want lat=5 err=0", lat, err); end
        if (load_vec !== v) begin bad++; $display("FAIL after_busy_load got=%h want=%h", load_vec, v); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_misaligned();
        test_wrap();
        test_random();
        test_reset_mid();
        test_start_busy();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
